// File: rtl/renode_aximem_pkg.sv
// rtl/renode_aximem_pkg.sv - AXI4 types, response codes and FSM states for renode_memory.
package renode_aximem_pkg;

    localparam int AddrWidth = 32;
    localparam int DataWidth = 32;
    localparam int IdWidth   = 3;
    localparam int UserWidth = 1;
    localparam int StrbWidth = DataWidth / 8;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [UserWidth-1:0] user_t;
    typedef logic [7:0]           len_t;
    typedef logic [2:0]           size_t;
    typedef logic [1:0]           burst_t;
    typedef logic [1:0]           resp_t;

    localparam resp_t OKAY   = 2'd0;
    localparam resp_t EXOKAY = 2'd1;
    localparam resp_t SLVERR = 2'd2;
    localparam resp_t DECERR = 2'd3;

    localparam burst_t BURST_FIXED = 2'd0;
    localparam burst_t BURST_INCR  = 2'd1;
    localparam burst_t BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } mem_state_e;

    typedef struct packed {
        id_t    aw_id;
        addr_t  aw_addr;
        len_t   aw_len;
        size_t  aw_size;
        burst_t aw_burst;
        logic   aw_valid;
        data_t  w_data;
        strb_t  w_strb;
        logic   w_last;
        logic   w_valid;
        logic   b_ready;
        id_t    ar_id;
        addr_t  ar_addr;
        len_t   ar_len;
        size_t  ar_size;
        burst_t ar_burst;
        logic   ar_valid;
        logic   r_ready;
    } axi_connection_req_t;

    typedef struct packed {
        logic  aw_ready;
        logic  w_ready;
        logic  ar_ready;
        logic  b_valid;
        id_t   b_id;
        resp_t b_resp;
        user_t b_user;
        logic  r_valid;
        id_t   r_id;
        data_t r_data;
        resp_t r_resp;
        logic  r_last;
        user_t r_user;
    } axi_connection_resp_t;

    // Encodings rank by severity for the codes this slave can produce.
    function automatic resp_t worst_resp(input resp_t a, input resp_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/renode_memory_array.sv
// rtl/renode_memory_array.sv - MemWords x 32-bit storage, byte write enables, combinational read.
module renode_memory_array
    import renode_aximem_pkg::*;
#(
    parameter int unsigned MemWords = 1024,
    localparam int unsigned IdxW = $clog2(MemWords)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] addr_i,
    input  data_t           wdata_i,
    input  strb_t           be_i,
    output data_t           rdata_o
);

    // Contents survive reset on purpose.
    data_t mem_q [MemWords];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/renode_memory.sv
// rtl/renode_memory.sv - AXI4 memory slave, one outstanding burst; WRAP bursts need RENODE_MEMORY_WRAP_BURST_EN.
module renode_memory
    import renode_aximem_pkg::*;
#(
    parameter addr_t       BaseAddr = 32'h0000_0000,
    parameter int unsigned MemWords = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  axi_connection_req_t  axi_req_i,
    output axi_connection_resp_t axi_resp_o
);

    localparam int unsigned IdxW = $clog2(MemWords);

    typedef logic [AddrWidth:0] ext_addr_t;
    localparam ext_addr_t MemBytes = ext_addr_t'(MemWords) << 2;

    mem_state_e state_q, state_d;
    id_t        id_q, id_d;
    addr_t      addr_q, addr_d;
    len_t       len_q, len_d;
    len_t       beat_q, beat_d;
    size_t      size_q, size_d;
    burst_t     burst_q, burst_d;
    resp_t      bresp_q, bresp_d;

    ext_addr_t       offset;
    logic [IdxW-1:0] word_idx;
    logic            burst_ok;
    resp_t           beat_resp;
    addr_t           incr;
    addr_t           addr_next;
    logic            mem_we;
    data_t           mem_rdata;
    logic            unused_w_last;

    assign unused_w_last = axi_req_i.w_last;

`ifdef RENODE_MEMORY_WRAP_BURST_EN
    addr_t wrap_mask;

    assign burst_ok = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR) ||
                      ((burst_q == BURST_WRAP) &&
                       (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15));
    assign wrap_mask = ((addr_t'(len_q) + addr_t'(1)) << size_q) - addr_t'(1);
`else
    assign burst_ok = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
`endif

    // Per-beat decode of the current address; the offset is one bit wider so a
    // low address cannot alias into range.
    always_comb begin
        offset   = ext_addr_t'(addr_q) - ext_addr_t'(BaseAddr);
        word_idx = offset[IdxW+1:2];
        if (size_q > 3'd2 || !burst_ok) begin
            beat_resp = SLVERR;
        end else if (addr_q < BaseAddr || offset >= MemBytes) begin
            beat_resp = DECERR;
        end else begin
            beat_resp = OKAY;
        end
    end

    always_comb begin
        incr      = addr_t'(1) << size_q;
        addr_next = addr_q + incr;
        if (burst_q == BURST_FIXED) begin
            addr_next = addr_q;
        end
`ifdef RENODE_MEMORY_WRAP_BURST_EN
        else if (burst_q == BURST_WRAP) begin
            addr_next = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
        end
`endif
    end

    renode_memory_array #(
        .MemWords(MemWords)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .addr_i (word_idx),
        .wdata_i(axi_req_i.w_data),
        .be_i   (axi_req_i.w_strb),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        size_d     = size_q;
        burst_d    = burst_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        axi_resp_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                axi_resp_o.aw_ready = 1'b1;
                // A pending write takes priority, so the read is held off.
                axi_resp_o.ar_ready = !axi_req_i.aw_valid;
                if (axi_req_i.aw_valid) begin
                    id_d    = axi_req_i.aw_id;
                    addr_d  = axi_req_i.aw_addr;
                    len_d   = axi_req_i.aw_len;
                    size_d  = axi_req_i.aw_size;
                    burst_d = axi_req_i.aw_burst;
                    beat_d  = '0;
                    bresp_d = OKAY;
                    state_d = ST_WDATA;
                end else if (axi_req_i.ar_valid) begin
                    id_d    = axi_req_i.ar_id;
                    addr_d  = axi_req_i.ar_addr;
                    len_d   = axi_req_i.ar_len;
                    size_d  = axi_req_i.ar_size;
                    burst_d = axi_req_i.ar_burst;
                    beat_d  = '0;
                    state_d = ST_RDATA;
                end
            end
            ST_WDATA: begin
                axi_resp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    mem_we  = (beat_resp == OKAY);
                    bresp_d = worst_resp(bresp_q, beat_resp);
                    addr_d  = addr_next;
                    beat_d  = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b_id    = id_q;
                axi_resp_o.b_resp  = bresp_q;
                if (axi_req_i.b_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r_id    = id_q;
                axi_resp_o.r_resp  = beat_resp;
                axi_resp_o.r_data  = (beat_resp == OKAY) ? mem_rdata : '0;
                axi_resp_o.r_last  = (beat_q == len_q);
                if (axi_req_i.r_ready) begin
                    addr_d = addr_next;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst_i) begin
            axi_resp_o = '0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            bresp_q <= OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: tb/tb_renode_memory.sv
// tb/tb_renode_memory.sv - randomized bench for renode_memory against a per-beat reference model.
module tb_renode_memory;
    import renode_aximem_pkg::*;

    localparam addr_t BASE    = 32'h0000_0000;
    localparam int    WORDS   = 128;
    localparam int    TIMEOUT = 400;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    axi_connection_req_t  req;
    axi_connection_resp_t resp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];
    logic [31:0] last_rdata;

    always #5 clk_i = ~clk_i;

    renode_memory #(
        .BaseAddr(BASE),
        .MemWords(WORDS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint m_addr(input longint start, input int size, input int burst,
                                      input int len, input int beat);
        longint step;
        longint win;
        longint lo;
        step = longint'(1) << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            win = step * (len + 1);
            lo  = start - (start % win);
            return lo + ((start - lo + beat * step) % win);
        end
        return start + beat * step;
    endfunction

    function automatic logic [1:0] m_resp(input longint a, input int size, input int burst, input int len);
        bit wrap_ok;
`ifdef RENODE_MEMORY_WRAP_BURST_EN
        wrap_ok = (len == 1 || len == 3 || len == 7 || len == 15);
`else
        wrap_ok = 1'b0;
`endif
        if (size > 2) return SLVERR;
        if (burst == 3 || (burst == 2 && !wrap_ok)) return SLVERR;
        if (a < longint'(BASE) || a >= longint'(BASE) + 4 * WORDS) return DECERR;
        return OKAY;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input int size,
                               input int burst, output logic [1:0] worst);
        longint     a;
        logic [1:0] r;
        int         idx;
        worst = OKAY;
        for (int i = 0; i <= len; i++) begin
            a = m_addr(longint'(addr), size, burst, len, i);
            r = m_resp(a, size, burst, len);
            if (r > worst) worst = r;
            if (r == OKAY) begin
                idx = int'((a - longint'(BASE)) >> 2);
                for (int b = 0; b < 4; b++) begin
                    if (ws_q[i][b]) ref_mem[idx][8*b +: 8] = wd_q[i][8*b +: 8];
                end
            end
        end
    endtask

    task automatic aw_phase(input id_t id, input addr_t addr, input len_t len, input size_t size, input burst_t burst);
        int n = 0;
        req.aw_id = id; req.aw_addr = addr; req.aw_len = len;
        req.aw_size = size; req.aw_burst = burst; req.aw_valid = 1'b1;
        #1;
        while (!resp.aw_ready && n < TIMEOUT) begin @(negedge clk_i); #1; n++; end
        check_eq("aw_handshake", resp.aw_ready, 1);
        @(negedge clk_i);
        req.aw_valid = 1'b0;
    endtask

    task automatic ar_phase(input id_t id, input addr_t addr, input len_t len, input size_t size, input burst_t burst);
        int n = 0;
        req.ar_id = id; req.ar_addr = addr; req.ar_len = len;
        req.ar_size = size; req.ar_burst = burst; req.ar_valid = 1'b1;
        #1;
        while (!resp.ar_ready && n < TIMEOUT) begin @(negedge clk_i); #1; n++; end
        check_eq("ar_handshake", resp.ar_ready, 1);
        @(negedge clk_i);
        req.ar_valid = 1'b0;
    endtask

    task automatic w_phase(input int len);
        int n;
        for (int i = 0; i <= len; i++) begin
            req.w_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            req.w_valid = 1'b1;
            req.w_data  = wd_q[i];
            req.w_strb  = ws_q[i];
            req.w_last  = (i == len);
            n = 0;
            #1;
            while (!resp.w_ready && n < TIMEOUT) begin @(negedge clk_i); #1; n++; end
            if (n >= TIMEOUT) check_eq("w_handshake", resp.w_ready, 1);
            @(negedge clk_i);
        end
        req.w_valid = 1'b0;
        req.w_last  = 1'b0;
    endtask

    task automatic b_phase(input id_t id, input logic [1:0] exp_resp);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < TIMEOUT) begin
            req.b_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (resp.b_valid && req.b_ready) begin
                got = 1'b1;
                check_eq("b_id", resp.b_id, id);
                check_eq("b_resp", resp.b_resp, exp_resp);
                check_eq("b_user", resp.b_user, 0);
            end
            @(negedge clk_i);
            n++;
        end
        req.b_ready = 1'b0;
        check_eq("b_handshake", got, 1);
    endtask

    task automatic r_phase(input id_t id, input logic [31:0] addr, input int len, input int size, input int burst);
        int          n = 0;
        int          i = 0;
        bit          have_prev = 1'b0;
        logic [31:0] prev = '0;
        longint      a;
        logic [1:0]  er;
        logic [31:0] ed;
        while (i <= len && n < TIMEOUT) begin
            req.r_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (resp.r_valid) begin
                if (have_prev) check_eq("r_stable", resp.r_data, prev);
                if (req.r_ready) begin
                    a  = m_addr(longint'(addr), size, burst, len, i);
                    er = m_resp(a, size, burst, len);
                    ed = (er == OKAY) ? ref_mem[int'((a - longint'(BASE)) >> 2)] : 32'h0;
                    check_eq("r_data", resp.r_data, ed);
                    check_eq("r_resp", resp.r_resp, er);
                    check_eq("r_last", resp.r_last, (i == len));
                    check_eq("r_id", resp.r_id, id);
                    check_eq("r_user", resp.r_user, 0);
                    last_rdata = resp.r_data;
                    have_prev  = 1'b0;
                    i++;
                end else begin
                    prev      = resp.r_data;
                    have_prev = 1'b1;
                end
            end
            @(negedge clk_i);
            n++;
        end
        req.r_ready = 1'b0;
        check_eq("r_beats", i, len + 1);
    endtask

    task automatic write_txn(input id_t id, input logic [31:0] addr, input int len, input int size, input int burst);
        logic [1:0] worst;
        model_write(addr, len, size, burst, worst);
        aw_phase(id, addr, len_t'(len), size_t'(size), burst_t'(burst));
        w_phase(len);
        b_phase(id, worst);
    endtask

    task automatic read_txn(input id_t id, input logic [31:0] addr, input int len, input int size, input int burst);
        ar_phase(id, addr, len_t'(len), size_t'(size), burst_t'(burst));
        r_phase(id, addr, len, size, burst);
    endtask

    task automatic load_one(input logic [31:0] d, input logic [3:0] s);
        wd_q.delete(); ws_q.delete();
        wd_q.push_back(d); ws_q.push_back(s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  worst;
        logic [31:0] old_word;
        int          len, size, burst;
        logic [31:0] addr;

        req   = '0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_aw_ready", resp.aw_ready, 0);
        check_eq("rst_ar_ready", resp.ar_ready, 0);
        check_eq("rst_w_ready", resp.w_ready, 0);
        check_eq("rst_b_valid", resp.b_valid, 0);
        check_eq("rst_r_valid", resp.r_valid, 0);
        check_eq("rst_r_data", resp.r_data, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("idle_aw_ready", resp.aw_ready, 1);
        check_eq("idle_ar_ready", resp.ar_ready, 1);
        @(negedge clk_i);

        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            wd_q.push_back($urandom()); ws_q.push_back(4'hF);
        end
        write_txn(3'd1, 32'h0, WORDS - 1, 2, 1);

        load_one(32'hDEAD_BEEF, 4'hF);
        write_txn(3'd0, 32'h10, 0, 2, 1);
        read_txn(3'd0, 32'h10, 0, 2, 1);
        check_eq("single_rdata", last_rdata, 32'hDEAD_BEEF);

        wd_q.delete(); ws_q.delete();
        for (int i = 1; i <= 4; i++) begin wd_q.push_back(i); ws_q.push_back(4'hF); end
        write_txn(3'd5, 32'h100, 3, 2, 1);
        read_txn(3'd5, 32'h100, 3, 2, 1);
        check_eq("incr_last_rdata", last_rdata, 32'h4);

        load_one(32'hFFFF_FFFF, 4'hF);
        write_txn(3'd2, 32'h20, 0, 2, 1);
        load_one(32'hAAAA_5555, 4'h3);
        write_txn(3'd2, 32'h20, 0, 2, 1);
        read_txn(3'd2, 32'h20, 0, 2, 1);
        check_eq("strb_merge", last_rdata, 32'hFFFF_5555);

        load_one(32'h1234_5678, 4'hF);
        model_write(32'h40, 0, 2, 1, worst);
        req.ar_id = 3'd6; req.ar_addr = 32'h40; req.ar_len = 8'd0;
        req.ar_size = 3'd2; req.ar_burst = BURST_INCR; req.ar_valid = 1'b1;
        req.aw_id = 3'd4; req.aw_addr = 32'h40; req.aw_len = 8'd0;
        req.aw_size = 3'd2; req.aw_burst = BURST_INCR; req.aw_valid = 1'b1;
        #1;
        check_eq("both_ar_ready", resp.ar_ready, 0);
        check_eq("both_aw_ready", resp.aw_ready, 1);
        aw_phase(3'd4, 32'h40, 8'd0, 3'd2, BURST_INCR);
        w_phase(0);
        #1;
        check_eq("ar_wait_wresp", resp.ar_ready, 0);
        b_phase(3'd4, worst);
        read_txn(3'd6, 32'h40, 0, 2, 1);
        check_eq("aw_ar_new_data", last_rdata, 32'h1234_5678);

        read_txn(3'd1, 32'(4 * WORDS), 0, 2, 1);
        read_txn(3'd1, 32'(4 * WORDS - 8), 3, 2, 1);
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 4; i++) begin wd_q.push_back($urandom()); ws_q.push_back(4'hF); end
        write_txn(3'd3, 32'(4 * WORDS - 8), 3, 2, 1);
        read_txn(3'd3, 32'(4 * WORDS - 8), 1, 2, 1);
        load_one(32'h0BAD_0BAD, 4'hF);
        write_txn(3'd7, 32'h30, 0, 3, 1);
        read_txn(3'd7, 32'h30, 1, 2, 1);

        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 3; i++) begin wd_q.push_back(32'hF0 + i); ws_q.push_back(4'hF); end
        write_txn(3'd2, 32'h50, 2, 2, 0);
        read_txn(3'd2, 32'h50, 0, 2, 1);
        check_eq("fixed_last_wins", last_rdata, 32'hF2);

        ar_phase(3'd3, 32'h0, 8'd7, 3'd2, BURST_INCR);
        req.r_ready = 1'b1;
        #1;
        check_eq("rst_mid_beat0_valid", resp.r_valid, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_r_valid", resp.r_valid, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("post_rst_r_valid", resp.r_valid, 0);
        check_eq("post_rst_aw_ready", resp.aw_ready, 1);
        req.r_ready = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("post_rst_quiet", resp.r_valid, 0);
        @(negedge clk_i);
        read_txn(3'd3, 32'h0, 7, 2, 1);

        old_word = ref_mem[4];
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA000_0000 + i); ws_q.push_back(4'hF); end
        write_txn(3'd1, 32'h18, 3, 2, 2);
        read_txn(3'd1, 32'h18, 3, 2, 2);
        read_txn(3'd1, 32'h10, 0, 2, 1);
`ifdef RENODE_MEMORY_WRAP_BURST_EN
        check_eq("wrap_third_beat", last_rdata, 32'hA000_0002);
`else
        check_eq("wrap_no_write", last_rdata, old_word);
`endif

        for (int t = 0; t < 60; t++) begin
            len   = $urandom_range(0, 7);
            size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            burst = $urandom_range(0, 2);
            addr  = $urandom_range(0, 4 * WORDS + 31) & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 1) == 0) begin
                wd_q.delete(); ws_q.delete();
                for (int i = 0; i <= len; i++) begin
                    wd_q.push_back($urandom()); ws_q.push_back(4'($urandom_range(0, 15)));
                end
                write_txn(id_t'($urandom_range(0, 7)), addr, len, size, burst);
            end else begin
                read_txn(id_t'($urandom_range(0, 7)), addr, len, size, burst);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
